// File: rtl/ssd1309_spi_sink_pkg.sv
// Shared definitions for the SSD1309 SPI receive model: opcodes, address
// modes, framebuffer entry layout and small decode helpers.
package ssd1309_pkg;

    localparam logic [7:0] OP_ADDR_MODE  = 8'h20;
    localparam logic [7:0] OP_COL_ADDR   = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR  = 8'h22;
    localparam logic [7:0] OP_PAGE_START = 8'hB0;

    localparam int DEF_COLS  = 128;
    localparam int DEF_PAGES = 8;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_WRITE = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [7:0] col;
        logic [7:0] page;
        logic [7:0] data;
    } fb_entry_t;

    // Panel commands that carry one argument we do not model.
    function automatic logic is_skip1(input logic [7:0] op);
        case (op)
            8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hFD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/ssd1309_spi_sink_if.sv
// Framebuffer write port: the sink drives address/data/we (master), the
// framebuffer answers with busy and a write acknowledge (slave).
interface ssd1309_spi_sink_if;
    logic       fb_we;
    logic [7:0] fb_w_xpos;
    logic [7:0] fb_w_ypos;
    logic [7:0] fb_din;
    logic       fb_busy;
    logic       fb_w_data_valid;

    modport master (
        output fb_we, fb_w_xpos, fb_w_ypos, fb_din,
        input  fb_busy, fb_w_data_valid
    );

    modport slave (
        input  fb_we, fb_w_xpos, fb_w_ypos, fb_din,
        output fb_busy, fb_w_data_valid
    );
endinterface

// File: rtl/ssd1309_spi_sink_deser.sv
// SPI deserialiser: synchronises the panel pins into clk, detects sclk rising
// edges and assembles MSB-first bytes, tagging each with the D/C level seen on
// its last bit. A cs rise or a panel reset throws away a partial byte.
module ssd1309_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       cmd,
    input  logic       cs,
    input  logic       res,
    output logic [7:0] rx_byte,
    output logic       rx_is_data,
    output logic       rx_stb,
    output logic       res_ok
);
    // Pin order in the synchroniser: {sclk, sdin, cmd, cs, res}; idle levels
    // are cs and res high so reset never looks like a selected/held panel.
    localparam logic [4:0] PIN_IDLE = 5'b00011;

    logic [4:0] sync_sr [SYNC_STAGES];
    logic [4:0] pins_s;
    logic       sclk_q;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       sclk_s, sdin_s, cmd_s, cs_s, res_s, sclk_rise;

    assign pins_s = sync_sr[SYNC_STAGES-1];
    assign {sclk_s, sdin_s, cmd_s, cs_s, res_s} = pins_s;
    assign sclk_rise = sclk_s && !sclk_q;
    assign res_ok    = res_s;

    // Multi-stage synchroniser for all asynchronous panel pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_sr[i] <= PIN_IDLE;
            sclk_q <= 1'b0;
        end else begin
            sync_sr[0] <= {sclk, sdin, cmd, cs, res};
            for (int i = 1; i < SYNC_STAGES; i++) sync_sr[i] <= sync_sr[i-1];
            sclk_q <= sclk_s;
        end
    end

    // Shift on selected sclk rises; a one-clk strobe marks each full byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            rx_byte    <= 8'd0;
            rx_is_data <= 1'b0;
            rx_stb     <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            if (!res_s || cs_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shreg <= {shreg[5:0], sdin_s};
                if (bit_cnt == 3'd7) begin
                    bit_cnt    <= 3'd0;
                    rx_byte    <= {shreg, sdin_s};
                    rx_is_data <= cmd_s;
                    rx_stb     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: rtl/ssd1309_spi_sink.sv
// SSD1309 4-wire SPI sink: decodes addressing commands, tracks column/page
// pointers and writes received display bytes into a framebuffer through a
// small FIFO. Define SINK_STATS_EN to add saturating cmd/data byte counters.
module ssd1309_spi_sink
    import ssd1309_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int PAGES       = DEF_PAGES,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sdin,
    input  logic cmd,
    input  logic cs,
    input  logic res,
    ssd1309_spi_sink_if.master fb,
    output logic overflow
`ifdef SINK_STATS_EN
    ,
    output logic [15:0] cmd_count,
    output logic [15:0] data_count
`endif
);
    localparam logic [7:0] COL_MAX  = 8'(COLS - 1);
    localparam logic [7:0] PAGE_MAX = 8'(PAGES - 1);
    localparam int         AW       = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       rx_is_data, rx_stb, res_ok;

    ssd1309_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk, .rst, .sclk, .sdin, .cmd, .cs, .res,
        .rx_byte, .rx_is_data, .rx_stb, .res_ok
    );

    // ---------------- address state ----------------
    addr_mode_t mode;
    logic [7:0] col, page, col_start, col_end, page_start, page_end, pend_op;
    logic [7:0] col_inc, page_inc, arg_col, arg_page;
    logic [1:0] arg_cnt;

    assign col_inc  = (col  >= COL_MAX)  ? 8'd0 : col + 8'd1;
    assign page_inc = (page >= PAGE_MAX) ? 8'd0 : page + 8'd1;
    assign arg_col  = clamp8(rx_byte, COL_MAX);
    assign arg_page = clamp8(rx_byte, PAGE_MAX);

    // Command decode and pointer advance; panel reset restores the defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_PAGE; col <= '0; page <= '0; arg_cnt <= '0; pend_op <= '0;
            col_start <= '0; col_end <= COL_MAX; page_start <= '0; page_end <= PAGE_MAX;
        end else if (!res_ok) begin
            mode <= MODE_PAGE; col <= '0; page <= '0; arg_cnt <= '0; pend_op <= '0;
            col_start <= '0; col_end <= COL_MAX; page_start <= '0; page_end <= PAGE_MAX;
        end else if (rx_stb && rx_is_data) begin
            arg_cnt <= 2'd0;
            case (mode)
                MODE_HORIZ: begin
                    if (col == col_end) begin
                        col  <= col_start;
                        page <= (page == page_end) ? page_start : page_inc;
                    end else col <= col_inc;
                end
                MODE_VERT: begin
                    if (page == page_end) begin
                        page <= page_start;
                        col  <= (col == col_end) ? col_start : col_inc;
                    end else page <= page_inc;
                end
                default: col <= col_inc;
            endcase
        end else if (rx_stb && arg_cnt != 2'd0) begin
            arg_cnt <= arg_cnt - 2'd1;
            case (pend_op)
                OP_ADDR_MODE: if (rx_byte[1:0] != 2'd3) mode <= addr_mode_t'(rx_byte[1:0]);
                OP_COL_ADDR: begin
                    if (arg_cnt == 2'd2) begin col_start <= arg_col; col <= arg_col; end
                    else col_end <= arg_col;
                end
                OP_PAGE_ADDR: begin
                    if (arg_cnt == 2'd2) begin page_start <= arg_page; page <= arg_page; end
                    else page_end <= arg_page;
                end
                default: ;
            endcase
        end else if (rx_stb) begin
            pend_op <= rx_byte;
            if (rx_byte == OP_ADDR_MODE || is_skip1(rx_byte)) arg_cnt <= 2'd1;
            else if (rx_byte == OP_COL_ADDR || rx_byte == OP_PAGE_ADDR) arg_cnt <= 2'd2;
            else if (rx_byte[7:4] == 4'h0) begin
                if (mode == MODE_PAGE) col <= clamp8({col[7:4], rx_byte[3:0]}, COL_MAX);
            end else if (rx_byte[7:4] == 4'h1) begin
                if (mode == MODE_PAGE) col <= clamp8({rx_byte[3:0], col[3:0]}, COL_MAX);
            end else if (rx_byte[7:3] == OP_PAGE_START[7:3]) begin
                page <= clamp8({5'd0, rx_byte[2:0]}, PAGE_MAX);
            end
        end
    end

    // ---------------- data FIFO ----------------
    fb_entry_t   mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop, full, empty;
    fb_entry_t   head;

    assign push  = rx_stb && rx_is_data;
    assign full  = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // FIFO pointers; a push into a full FIFO is dropped and flagged stickily.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && full)  overflow <= 1'b1;
            if (push && !full) wr_ptr   <= wr_ptr + 1'b1;
            if (pop)           rd_ptr   <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; captures the pointers before they advance.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= {col, page, rx_byte};
    end

    // ---------------- framebuffer writer ----------------
    wr_state_t  state, state_n;
    logic       we_q;
    logic [7:0] xpos_q, ypos_q, din_q;

    assign fb.fb_we     = we_q;
    assign fb.fb_w_xpos = xpos_q;
    assign fb.fb_w_ypos = ypos_q;
    assign fb.fb_din    = din_q;

    // Writer next state: pop when idle and the framebuffer can take a write.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            W_IDLE:  if (!empty && !fb.fb_busy) begin pop = 1'b1; state_n = W_WRITE; end
            W_WRITE: if (fb.fb_w_data_valid) state_n = W_IDLE;
            default: state_n = W_IDLE;
        endcase
    end

    // Writer state and output registers, held until the write is acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= W_IDLE; we_q <= 1'b0;
            xpos_q <= '0; ypos_q <= '0; din_q <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                we_q <= 1'b1; xpos_q <= head.col; ypos_q <= head.page; din_q <= head.data;
            end else if (state == W_WRITE && fb.fb_w_data_valid) begin
                we_q <= 1'b0;
            end
        end
    end

`ifdef SINK_STATS_EN
    // Saturating byte counters; only the system reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count  <= '0;
            data_count <= '0;
        end else if (rx_stb) begin
            if (!rx_is_data && cmd_count  != 16'hFFFF) cmd_count  <= cmd_count  + 16'd1;
            if ( rx_is_data && data_count != 16'hFFFF) data_count <= data_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ssd1309_spi_sink.sv
// Bench for ssd1309_spi_sink: bit-bangs SPI bytes, queues the expected
// framebuffer writes and compares them as the writer presents them.
`timescale 1ns/1ps
module tb_ssd1309_spi_sink;
    logic clk = 1'b0, rst = 1'b1;
    logic sclk = 1'b0, sdin = 1'b0, cmd = 1'b0, cs = 1'b1, res = 1'b1;
    logic overflow;
`ifdef SINK_STATS_EN
    logic [15:0] cmd_count, data_count;
`endif

    ssd1309_spi_sink_if fb_bus();

    ssd1309_spi_sink dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .cmd(cmd), .cs(cs), .res(res),
        .fb(fb_bus), .overflow(overflow)
`ifdef SINK_STATS_EN
        , .cmd_count(cmd_count), .data_count(data_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] x, y, d; } exp_t;
    exp_t sb_q[$];
    int n_chk = 0, n_bad = 0, n_wr = 0;
    logic hold_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input logic dc);
        cmd = dc; cs = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdin = b[i];
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        spi_bits(b, 8, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
        sb_q.push_back('{x: x, y: y, d: b});
        spi_bits(b, 8, 1'b1);
    endtask

    task automatic do_rst();
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; res = 1'b1;
        fb_bus.fb_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !fb_bus.fb_we) break;
        end
        repeat (20) @(negedge clk);
        chk(tag, sb_q.size(), 0);
    endtask

    // Framebuffer model: check each presented write, acknowledge after a cycle.
    initial begin
        fb_bus.fb_w_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (fb_bus.fb_we === 1'b1 && !hold_ack) begin
                exp_t e;
                n_wr++;
                chk("exp_pending", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("wr_x", fb_bus.fb_w_xpos, e.x);
                    chk("wr_y", fb_bus.fb_w_ypos, e.y);
                    chk("wr_d", fb_bus.fb_din,    e.d);
                end
                @(negedge clk);
                chk("wr_hold", fb_bus.fb_we, 1);
                fb_bus.fb_w_data_valid = 1'b1;
                @(negedge clk);
                fb_bus.fb_w_data_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        fb_bus.fb_busy = 1'b0;
        do_rst();
        chk("rst_we",   fb_bus.fb_we, 0);
        chk("rst_x",    fb_bus.fb_w_xpos, 0);
        chk("rst_y",    fb_bus.fb_w_ypos, 0);
        chk("rst_din",  fb_bus.fb_din, 0);
        chk("rst_ovf",  overflow, 0);

        // Default PAGE mode from reset.
        send_data(8'hA5, 8'd0, 8'd0);
        send_data(8'h11, 8'd1, 8'd0);
        drain("drain_basic");

        // Horizontal mode inside a 2x2 window.
        do_rst();
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h03); send_cmd(8'h04);
        send_data(8'h01, 8'd126, 8'd3);
        send_data(8'h02, 8'd127, 8'd3);
        send_data(8'h03, 8'd126, 8'd4);
        send_data(8'h04, 8'd127, 8'd4);
        send_data(8'h05, 8'd126, 8'd3);
        drain("drain_horiz");

        // Vertical mode with default ranges.
        do_rst();
        send_cmd(8'h20); send_cmd(8'h01);
        for (int i = 0; i < 8; i++) send_data(8'(8'h40 + i), 8'd0, 8'(i));
        send_data(8'h48, 8'd1, 8'd0);
        drain("drain_vert");

        // Overflow while the framebuffer is busy.
        do_rst();
        fb_bus.fb_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_data(8'(8'hC0 + i), 8'(i), 8'd0);
        chk("no_ovf_yet", overflow, 0);
        spi_bits(8'hC4, 8, 1'b1);
        spi_bits(8'hC5, 8, 1'b1);
        chk("ovf_set", overflow, 1);
        chk("busy_no_we", fb_bus.fb_we, 0);
        wr0 = n_wr;
        fb_bus.fb_busy = 1'b0;
        drain("drain_ovf");
        chk("ovf_wr_cnt", n_wr - wr0, 4);
        chk("ovf_sticky", overflow, 1);

        // Nibble column set, page start, skipped argument that looks like 0x22.
        do_rst();
        send_cmd(8'hB5); send_cmd(8'h03); send_cmd(8'h12);
        send_cmd(8'h81); send_cmd(8'h22);
        send_data(8'hFF, 8'h23, 8'd5);
        send_data(8'hEE, 8'h24, 8'd5);
        drain("drain_nibble");

        // Clamped arguments, ignored mode 3, PAGE wrap at the last column.
        do_rst();
        send_cmd(8'h20); send_cmd(8'h03);
        send_cmd(8'h21); send_cmd(8'hF0); send_cmd(8'hFF);
        send_cmd(8'h22); send_cmd(8'h09); send_cmd(8'h0A);
        send_data(8'h81, 8'd127, 8'd7);
        send_data(8'h82, 8'd0,   8'd7);
        drain("drain_clamp");

        // Aborted partial byte, then panel reset restoring the address.
        do_rst();
        spi_bits(8'hFF, 5, 1'b1);
        send_data(8'h3C, 8'd0, 8'd0);
        send_data(8'h77, 8'd1, 8'd0);
        drain("drain_abort");
        res = 1'b0;
        repeat (8) @(negedge clk);
        res = 1'b1;
        repeat (4) @(negedge clk);
        send_data(8'h99, 8'd0, 8'd0);
        drain("drain_res");
        chk("res_keeps_ovf", overflow, 0);

        // System reset while a write is waiting for acknowledge.
        do_rst();
        hold_ack = 1'b1;
        spi_bits(8'h5A, 8, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (fb_bus.fb_we) break;
            @(negedge clk);
        end
        chk("hold_we", fb_bus.fb_we, 1);
        chk("hold_din", fb_bus.fb_din, 8'h5A);
        repeat (3) @(negedge clk);
        chk("hold_we_late", fb_bus.fb_we, 1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_we", fb_bus.fb_we, 0);
        chk("rst_mid_din", fb_bus.fb_din, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/ssd1309_spi_sink.md
Name: ssd1309_spi_sink

Overview:
- Receive side of the SSD1309 4-wire SPI link: deserialises SCLK/SDIN/DC/CS exactly as the OLED panel would.
- Decodes addressing commands and tracks column/page pointers.
- Writes each received display-data byte (8 vertical pixels) into a monochrome framebuffer through the standard we/busy/w_data_valid write port.
- Used as an on-chip shadow display and as the loopback target for verifying ssd1309_driver.

Parameters:
- COLS, 128, display width in columns; the column pointer wraps at COLS-1.
- PAGES, 8, number of 8-pixel pages; the page pointer wraps at PAGES-1.
- FIFO_DEPTH, 4, data-byte buffer depth between deserialiser and framebuffer writer; power of two.
- SYNC_STAGES, 2, flip-flop synchroniser depth on sclk/sdin/cmd/cs/res.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock (OLED d0); asynchronous to clk, at most clk/4.
- sdin  in  1  SPI data (OLED d1); MSB first, sampled on sclk rising edge.
- cmd  in  1  D/C line: 0 = command byte, 1 = display data.
- cs  in  1  chip select, active low.
- res  in  1  panel reset, active low; restores the address state.
- fb_busy  in  1  framebuffer busy.
- fb_w_data_valid  in  1  framebuffer write acknowledge.
- fb_we  out  1  write enable.
- fb_w_xpos  out  8  column.
- fb_w_ypos  out  8  page index.
- fb_din  out  8  pixel byte; bit0 = top row of page.
- overflow  out  1  sticky: a data byte was dropped.

Behaviour:
- Reset (rst high, async): fb_we=0, fb_w_xpos=0, fb_w_ypos=0, fb_din=0, overflow=0, FIFO empty, shift count 0.
  - Address mode = PAGE, col=0, page=0, col range 0..COLS-1, page range 0..PAGES-1, pending-argument count 0.
- Synchronised res low: the same address state is restored and the shift count is cleared. FIFO and overflow are kept.
- Deserialiser: on each synced sclk rising edge while synced cs=0, shift sdin into the byte. On the 8th bit, emit byte plus cmd sampled with that bit, in a one-clk strobe.
  - cs rising mid-byte discards the partial byte.
  - sclk edges while cs=1 are ignored.
- Command decode (cmd=0). When the argument count is nonzero, the byte is an argument.
  - 0x20: 1 argument, mode = arg[1:0]. 0 = HORIZ, 1 = VERT, 2 = PAGE; 3 is ignored.
  - 0x21: 2 arguments, col_start and col_end; col := col_start.
  - 0x22: 2 arguments, page_start and page_end; page := page_start.
  - 0x00-0x0F sets col[3:0]; 0x10-0x1F sets col[7:4]. Both apply in PAGE mode only.
  - 0xB0-0xB7 sets page = low 3 bits.
  - 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0xFD: 1 argument, skipped.
  - All other command bytes are ignored.
  - Argument values are clamped to COLS-1 or PAGES-1.
- Data byte (cmd=1): push {col, page, byte} into the FIFO, then advance the pointers the same cycle.
  - HORIZ: at col==col_end, col := col_start and page advances (page_end wraps to page_start); otherwise col+1.
  - VERT: at page==page_end, page := page_start and col advances with the same wrap; otherwise page+1.
  - PAGE: col+1, wrapping COLS-1 to 0; page is unchanged.
  - A data byte received while arguments are pending is treated as data and clears the pending count.
- FIFO full on push: the byte is dropped, overflow := 1, and the pointers still advance.
- Writer FSM:
  - IDLE: FIFO non-empty and !fb_busy -> WRITE. Pop the entry and drive the address/data registers with fb_we=1.
  - WRITE: hold all outputs until fb_w_data_valid=1. Then fb_we := 0 -> IDLE.
- Latency: fb_we rises no earlier than 2 clk after the byte-complete strobe. Push and pop in the same cycle are both allowed.
- rst mid-write drops fb_we immediately.

Optional Feature:
- Macro SINK_STATS_EN.
- Defined: adds outputs cmd_count[15:0] and data_count[15:0], both saturating. They count decoded command/argument bytes and data bytes, and are cleared by rst only.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ssd1309_pkg holds:
  - Opcode constants (OP_ADDR_MODE=0x20, OP_COL_ADDR=0x21, OP_PAGE_ADDR=0x22, OP_PAGE_START=0xB0, plus the 1-argument skip list).
  - Address-mode enum (HORIZ=0, VERT=1, PAGE=2).
  - Default ranges.
- One sub-module, ssd1309_spi_deser: synchroniser, edge detect, shift register and cs abort. It outputs byte, is_data and a strobe.

Test Plan:
- After rst, send data byte 0xA5: one write with x=0, y=0, din=0xA5; the next data byte goes to x=1.
- Send 0x20,0x00 then 0x21,0x7E,0x7F then 0x22,0x03,0x04, then 5 data bytes: writes land at (126,3), (127,3), (126,4), (127,4), (126,3).
- Send 0x20,0x01 with default ranges, then 9 data bytes: ypos sequence 0..7 at x=0, then (1,0).
- Hold fb_busy=1 and send 6 data bytes: first 4 are buffered, overflow=1. Release busy: exactly 4 writes in order.
- Send 0xB5, 0x03, 0x12, then 0x81, 0x22 (contrast argument), then data 0xFF: write at x=0x23, y=5, and the 0x22 is not decoded as a command.
- Raise cs after 5 bits, then send full data byte 0x3C: only 0x3C is written. Pulse res low: the next data byte goes to (0,0).
